// File: rtl/digital_clock_pkg.sv
// digital_clock_pkg: key indices, BCD field limits, packed time type and BCD increment helper
package digital_clock_pkg;
  localparam int KEY_RUN  = 0;
  localparam int KEY_CLR  = 1;
  localparam int KEY_HOUR = 2;
  localparam int KEY_MIN  = 3;
  localparam logic [7:0] CC_MAX   = 8'h99;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  typedef struct packed {
    logic [3:0] h10, h1, m10, m1, s10, s1, c10, c1;
  } bcd_time_t;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/digital_clock_key.sv
// digital_clock_key: 2-flop sync, optional debounce (KEY_DEBOUNCE_EN), rising-edge 1-cycle pulse
module digital_clock_key
`ifdef KEY_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 1_000_000)
`endif
  (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);
  logic s0, s1, lvl, lvl_d;
  // bring the asynchronous key into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= key;
      s1 <= s0;
    end
  end
`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  // filtered level follows only after the new level has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (s1 == lvl) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      lvl <= s1;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  end
`else
  assign lvl = s1;
`endif
  // previous level for edge detection
  always_ff @(posedge clk) lvl_d <= rst ? 1'b0 : lvl;
  assign pulse = lvl & ~lvl_d;
endmodule

// File: rtl/digital_clock.sv
// digital_clock: BCD HH:MM:SS.cc clock with run/clear/hour/minute keys; KEY_DEBOUNCE_EN adds key debounce
module digital_clock
  import digital_clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ = 100
`ifdef KEY_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 1_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  output logic [31:0] dout
);
  localparam int DIV_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
  localparam int W = DIV_MAX > 0 ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [W-1:0] DIV_TERM = W'(DIV_MAX);
  logic [W-1:0] div;
  logic [3:0] p;
  logic run, tick, kevt, inc_c, inc_s, inc_m, inc_h;
  logic [7:0] cc_n, ss_n, mm_n, hh_n;
  bcd_time_t t;
  for (genvar k = 0; k < 4; k++) begin : g_key
    digital_clock_key
`ifdef KEY_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_key (.clk(clk), .rst(rst), .key(key[k]), .pulse(p[k]));
  end
  assign cc_n = bcd_inc({t.c10, t.c1}, CC_MAX);
  assign ss_n = bcd_inc({t.s10, t.s1}, SEC_MAX);
  assign mm_n = bcd_inc({t.m10, t.m1}, MIN_MAX);
  assign hh_n = bcd_inc({t.h10, t.h1}, HOUR_MAX);
  // key pulses 1-3 override and discard a coincident tick; otherwise the tick ripples the carry chain
  always_comb begin
    kevt = |p[3:1];
    tick = run && div == DIV_TERM;
    inc_c = !kevt && tick;
    inc_s = inc_c && {t.c10, t.c1} == CC_MAX;
    inc_m = kevt ? p[KEY_MIN] : inc_s && {t.s10, t.s1} == SEC_MAX;
    inc_h = kevt ? p[KEY_HOUR] : inc_m && {t.m10, t.m1} == MIN_MAX;
  end
  // centisecond divider and run flag; a run toggle takes effect after the current tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      run <= 1'b1;
    end else begin
      run <= run ^ p[KEY_RUN];
      div <= p[KEY_CLR] ? '0 : !run ? div : tick ? '0 : div + 1'b1;
    end
  end
  // time-of-day register, driven straight onto dout
  always_ff @(posedge clk) begin
    if (rst) t <= '0;
    else begin
      if (p[KEY_CLR]) {t.s10, t.s1, t.c10, t.c1} <= '0;
      if (inc_c) {t.c10, t.c1} <= cc_n;
      if (inc_s) {t.s10, t.s1} <= ss_n;
      if (inc_m) {t.m10, t.m1} <= mm_n;
      if (inc_h) {t.h10, t.h1} <= hh_n;
    end
  end
  assign dout = t;
endmodule

// File: tb/tb_digital_clock.sv
// tb_digital_clock: directed + random stimulus against a centisecond-count reference model
module tb_digital_clock;
  localparam int DIV = 1000 / 100;
  localparam int DAY = 24 * 3600 * 100;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] key = 4'h0;
  logic [31:0] dout;
  int tests = 0, fails = 0;
  int m_cs, m_div;
  logic m_run;
  logic [3:0] q0, q1, q2;

  always #5 clk = ~clk;

  digital_clock #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (.clk(clk), .rst(rst), .key(key), .dout(dout));

  function automatic logic [31:0] to_bcd(input int cs);
    int hh, mm, ss, cc;
    hh = cs / 360000;
    mm = (cs / 6000) % 60;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [31:0] d);
    for (int i = 0; i < 8; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
    return d[31:24] <= 8'h23 && d[23:20] <= 4'd5 && d[15:12] <= 4'd5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // key pulse reaches the time registers two edges after the key is first sampled high
  task automatic model(input logic [3:0] k, input logic r);
    logic [3:0] p;
    bit tk;
    int hh, mm, ss, cc;
    if (r) begin
      m_cs = 0; m_div = 0; m_run = 1'b1; q0 = 0; q1 = 0; q2 = 0;
      return;
    end
    p = q1 & ~q2;
    q2 = q1; q1 = q0; q0 = k;
    tk = m_run && m_div == DIV - 1;
    if (|p[3:1]) begin
      hh = m_cs / 360000; mm = (m_cs / 6000) % 60; ss = (m_cs / 100) % 60; cc = m_cs % 100;
      if (p[1]) begin ss = 0; cc = 0; end
      if (p[2]) hh = (hh + 1) % 24;
      if (p[3]) mm = (mm + 1) % 60;
      m_cs = hh * 360000 + mm * 6000 + ss * 100 + cc;
    end else if (tk) m_cs = (m_cs + 1) % DAY;
    m_div = p[1] ? 0 : m_run ? (m_div + 1) % DIV : m_div;
    m_run = m_run ^ p[0];
  endtask

  task automatic step(input logic [3:0] k, input logic r = 1'b0);
    key = k;
    rst = r;
    @(posedge clk);
    model(k, r);
    #1;
    check("model", dout, to_bcd(m_cs));
    check("bcd", 32'(bcd_ok(dout)), 32'h1);
  endtask

  task automatic press(input logic [3:0] k);
    step(k);
    step(4'h0);
    step(4'h0);
  endtask

  initial begin
    int n, cs0;
    repeat (3) step(4'h0, 1'b1);
    check("reset", dout, 32'h0);
    repeat (1000) step(4'h0);
    check("one_sec", dout, 32'h0000_0100);

    repeat (2) step(4'h0, 1'b1);
    step(4'b0100);
    step(4'b0100);
    check("hour_e1", 32'(dout[31:24]), 32'h00);
    step(4'b0100);
    check("hour_e2", 32'(dout[31:24]), 32'h01);
    repeat (97) step(4'b0100);
    check("hour_no_repeat", 32'(dout[31:24]), 32'h01);
    repeat (100) step(4'b1000);
    check("min_hold", 32'(dout[23:16]), 32'h01);
    step(4'h0);
    repeat (59) press(4'b1000);
    check("min_wrap", 32'(dout[23:16]), 32'h00);
    check("min_no_carry", 32'(dout[31:24]), 32'h01);

    repeat (2) step(4'h0, 1'b1);
    repeat (23) press(4'b0100);
    check("hour_23", 32'(dout[31:24]), 32'h23);
    press(4'b0100);
    check("hour_wrap", 32'(dout[31:24]), 32'h00);
    repeat (23) press(4'b0100);
    repeat (59) press(4'b1000);
    press(4'b0010);
    check("clr_2359", dout, 32'h2359_0000);
    n = 0;
    while (to_bcd(m_cs) != 32'h2359_5999 && n < 70000) begin step(4'h0); n++; end
    check("reach_max", dout, 32'h2359_5999);
    n = 0;
    while (m_cs != 0 && n < 20) begin step(4'h0); n++; end
    check("midnight", dout, 32'h0);

    press(4'b0001);
    cs0 = m_cs;
    repeat (500) step(4'h0);
    check("paused", dout, to_bcd(cs0));
    press(4'b0001);
    repeat (25) step(4'h0);
    check("resume_moved", 32'(dout != to_bcd(cs0)), 32'h1);

    repeat (2) step(4'h0, 1'b1);
    n = 0;
    while (to_bcd(m_cs) != 32'h0000_0537 && n < 6000) begin step(4'h0); n++; end
    check("at_0537", dout, 32'h0000_0537);
    press(4'b0010);
    check("clear", dout, 32'h0);
    repeat (9) step(4'h0);
    check("clear_hold", dout, 32'h0);
    step(4'h0);
    check("first_tick", dout, 32'h0000_0001);

    n = 0;
    while (m_div != DIV - 3 && n < 20) begin step(4'h0); n++; end
    cs0 = m_cs;
    step(4'b0100);
    step(4'h0);
    step(4'h0);
    check("tick_discard", dout, to_bcd(cs0 + 360000));

    repeat (37) step(4'h0);
    step(4'h0, 1'b1);
    check("rst_mid", dout, 32'h0);

    repeat (3000) begin
      logic [3:0] k;
      k = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(k, $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
